sht10_responder: RTL



---
 rtl/sht10_responder.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sht10_responder.sv
// SHT1x-compatible slave model: detects Transmission Start, accepts temp/RH commands,
// emulates the measurement delay and shifts out MSB, LSB and CRC bytes on an open-drain SDA.
module sht10_responder #(
    parameter int unsigned MEAS_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SCK,
    inout  wire         SDA,
    input  logic [13:0] temp_data,
    input  logic [11:0] rh_data,
    output logic        busy,
    output logic        cmd_err,
    output logic [4:0]  last_cmd
);

    typedef enum logic [2:0] {IDLE, RX_CMD, ACK_CMD, MEAS, TX_BIT, TX_ACK} state_t;
    typedef enum logic [1:0] {SD_SDA_FALL, SD_SCK_FALL, SD_SCK_RISE, SD_SDA_RISE} start_t;

    localparam logic [4:0]  CMD_TEMP = 5'b00011;
    localparam logic [4:0]  CMD_RH   = 5'b00101;
    localparam int unsigned MEAS_W   = $clog2(MEAS_CYCLES + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    logic sck_s1_q, sck_s2_q, sck_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;
    logic sck_rise, sck_fall, sda_rise, sda_fall;

    state_t              state_q, state_d;
    start_t              start_q, start_d;
    logic                start_done;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                sda_low_q, sda_low_d;
    logic                cmd_err_q, cmd_err_d;
    logic [4:0]          last_cmd_q, last_cmd_d;
    logic [MEAS_W-1:0]   meas_q, meas_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [23:0]         frame_q, frame_d;
    logic [1:0]          byte_q, byte_d;
    logic                ack_q, ack_d;
    logic                busy_q;
    logic                timeout;
    logic [7:0]          msb_w, lsb_w, crc_w;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = data[3'(7 - i)] ^ c[7];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = d[3'(7 - i)];
        end
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            sck_s1_q   <= SCK;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            sda_s1_q   <= SDA;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign sck_rise = sck_s2_q & ~sck_prev_q;
    assign sck_fall = ~sck_s2_q & sck_prev_q;
    assign sda_rise = sda_s2_q & ~sda_prev_q;
    assign sda_fall = ~sda_s2_q & sda_prev_q;

    // Start = SDA fall (SCK high), SCK fall, SCK rise, SDA rise (SCK high); any other edge restarts.
    always_comb begin
        start_d    = start_q;
        start_done = 1'b0;
        case (start_q)
            SD_SDA_FALL: if (sda_fall && sck_s2_q) start_d = SD_SCK_FALL;
            SD_SCK_FALL: begin
                if (sck_fall)                           start_d = SD_SCK_RISE;
                else if (sda_rise || sda_fall || sck_rise) start_d = SD_SDA_FALL;
            end
            SD_SCK_RISE: begin
                if (sck_rise)                           start_d = SD_SDA_RISE;
                else if (sda_rise || sda_fall || sck_fall) start_d = SD_SDA_FALL;
            end
            SD_SDA_RISE: begin
                if (sda_rise && sck_s2_q) begin
                    start_done = 1'b1;
                    start_d    = SD_SDA_FALL;
                end else if (sck_rise || sck_fall || sda_fall) begin
                    start_d = SD_SDA_FALL;
                end
            end
            default: start_d = SD_SDA_FALL;
        endcase
    end

    always_comb begin
        msb_w = '0;
        lsb_w = '0;
        if (last_cmd_q == CMD_RH) begin
            msb_w = {4'h0, rh_data[11:8]};
            lsb_w = rh_data[7:0];
        end else begin
            msb_w = {2'b00, temp_data[13:8]};
            lsb_w = temp_data[7:0];
        end
        crc_w = crc8_byte(crc8_byte(crc8_byte(8'h00, {3'b000, last_cmd_q}), msb_w), lsb_w);
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        sda_low_d  = sda_low_q;
        cmd_err_d  = cmd_err_q;
        last_cmd_d = last_cmd_q;
        meas_d     = meas_q;
        frame_d    = frame_q;
        byte_d     = byte_q;
        ack_d      = ack_q;

        if ((state_q == IDLE) || (state_q == MEAS) || sck_rise || sck_fall) to_d = '0;
        else                                                                 to_d = to_q + TO_W'(1);
        timeout = (state_q != IDLE) && (state_q != MEAS) && !sck_rise && !sck_fall &&
                  (to_q == TO_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            IDLE: ;
            // Bits are counted on rises so the SCK fall that closes the start sequence is ignored.
            RX_CMD: begin
                if (sck_rise) begin
                    shreg_d  = {shreg_q[6:0], sda_s2_q};
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (sck_fall && (bitcnt_q == 4'd8)) begin
                    if ((shreg_q[7:5] == 3'b000) &&
                        ((shreg_q[4:0] == CMD_TEMP) || (shreg_q[4:0] == CMD_RH))) begin
                        state_d   = ACK_CMD;
                        sda_low_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ACK_CMD: begin
                if (sck_fall) begin
                    sda_low_d  = 1'b0;
                    last_cmd_d = shreg_q[4:0];
                    meas_d     = '0;
                    state_d    = MEAS;
                end
            end
            MEAS: begin
                if (meas_q == MEAS_W'(MEAS_CYCLES)) begin
                    frame_d   = {msb_w, lsb_w, bitrev8(crc_w)};
                    bitcnt_d  = '0;
                    byte_d    = '0;
                    sda_low_d = ~msb_w[7];
                    state_d   = TX_BIT;
                end else begin
                    meas_d = meas_q + MEAS_W'(1);
                end
            end
            TX_BIT: begin
                if (sck_fall) begin
                    frame_d = {frame_q[22:0], 1'b0};
                    if (bitcnt_q == 4'd7) begin
                        bitcnt_d  = '0;
                        sda_low_d = 1'b0;
                        ack_d     = 1'b1;
                        state_d   = TX_ACK;
                    end else begin
                        bitcnt_d  = bitcnt_q + 4'd1;
                        sda_low_d = ~frame_q[22];
                    end
                end
            end
            TX_ACK: begin
                if (sck_rise) begin
                    ack_d = sda_s2_q;
                end else if (sck_fall) begin
                    if (!ack_q && (byte_q != 2'd2)) begin
                        byte_d    = byte_q + 2'd1;
                        sda_low_d = ~frame_q[23];
                        state_d   = TX_BIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
        end
        // A completed start wins over a coincident timeout.
        if (start_done) begin
            state_d   = RX_CMD;
            bitcnt_d  = '0;
            cmd_err_d = 1'b0;
            sda_low_d = 1'b0;
            to_d      = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= SD_SDA_FALL;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            sda_low_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            last_cmd_q <= '0;
            meas_q     <= '0;
            to_q       <= '0;
            frame_q    <= '0;
            byte_q     <= '0;
            ack_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            sda_low_q  <= sda_low_d;
            cmd_err_q  <= cmd_err_d;
            last_cmd_q <= last_cmd_d;
            meas_q     <= meas_d;
            to_q       <= to_d;
            frame_q    <= frame_d;
            byte_q     <= byte_d;
            ack_q      <= ack_d;
            busy_q     <= (state_q != IDLE);
        end
    end

    assign SDA      = sda_low_q ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;
    assign last_cmd = last_cmd_q;

endmodule
